// File: rtl/ifft_pkg.sv
// Shared types and constants for the 4-point IFFT: FSM states, component width,
// and the +j / -j twiddle words with their decode into a rotation select.
package ifft_pkg;

  localparam int COMP_W = 16;

  // Twiddles as complex words {re, im}; only pure rotations are ever applied.
  localparam logic [2*COMP_W-1:0] TW_POS_J = 32'h0000_7FFF;
  localparam logic [2*COMP_W-1:0] TW_NEG_J = 32'h0000_8001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGE1 = 2'd1,
    STAGE2 = 2'd2,
    DONE   = 2'd3
  } ifft_state_e;

  typedef enum logic [1:0] {
    TW_SEL_ONE   = 2'd0,
    TW_SEL_POS_J = 2'd1,
    TW_SEL_NEG_J = 2'd2
  } tw_sel_e;

  function automatic tw_sel_e tw_decode(input logic [2*COMP_W-1:0] w);
    if (w == TW_POS_J) return TW_SEL_POS_J;
    if (w == TW_NEG_J) return TW_SEL_NEG_J;
    return TW_SEL_ONE;
  endfunction

endpackage

// File: rtl/ifft_4point_if.sv
// Request/result bundle for ifft_4point, plus the FSM state for observation.
interface ifft_4point_if
  import ifft_pkg::*;
#(
  parameter int WIDTH = 2 * COMP_W
);

  // Handshake: start is sampled only in IDLE or DONE and launches a transform on
  // input0; done is a level that stays high while output0 holds a finished result
  // and drops on the edge that accepts the next start. There is no backpressure.
  logic                    start;
  logic signed [WIDTH-1:0] input0  [0:3];
  logic signed [WIDTH-1:0] output0 [0:3];
  logic                    done;
  ifft_state_e             state;

  modport master (
    output start,
    output input0,
    input  output0,
    input  done,
    input  state
  );

  modport slave (
    input  start,
    input  input0,
    output output0,
    output done,
    output state
  );

endinterface

// File: rtl/ifft_butterfly.sv
// Radix-2 butterfly: sum = a + t*b, diff = a - t*b with t in {1, +j, -j}.
// Defining IFFT_SCALE_EN halves each result (extra guard bit, floor shift).
module ifft_butterfly
  import ifft_pkg::*;
#(
  parameter int WIDTH = 2 * COMP_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  tw_sel_e          tw_sel,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] diff
);

  localparam int CW = WIDTH / 2;

  logic [CW-1:0] a_re;
  logic [CW-1:0] a_im;
  logic [CW-1:0] b_re;
  logic [CW-1:0] b_im;
  logic [CW-1:0] t_re;
  logic [CW-1:0] t_im;

  assign a_re = a[WIDTH-1:CW];
  assign a_im = a[CW-1:0];
  assign b_re = b[WIDTH-1:CW];
  assign b_im = b[CW-1:0];

  // Rotation by +/-j is a swap plus negate; the most negative value wraps to itself.
  always_comb begin
    t_re = b_re;
    t_im = b_im;
    case (tw_sel)
      TW_SEL_POS_J: begin
        t_re = -b_im;
        t_im = b_re;
      end
      TW_SEL_NEG_J: begin
        t_re = b_im;
        t_im = -b_re;
      end
      default: ;
    endcase
  end

  function automatic logic [CW-1:0] addsub(input logic [CW-1:0] x,
                                           input logic [CW-1:0] y,
                                           input logic          sub);
    logic signed [CW:0] r;
    r = sub ? ({x[CW-1], x} - {y[CW-1], y}) : ({x[CW-1], x} + {y[CW-1], y});
`ifdef IFFT_SCALE_EN
    return CW'(r >>> 1);
`else
    return CW'(r);
`endif
  endfunction

  assign sum  = {addsub(a_re, t_re, 1'b0), addsub(a_im, t_im, 1'b0)};
  assign diff = {addsub(a_re, t_re, 1'b1), addsub(a_im, t_im, 1'b1)};

endmodule

// File: rtl/ifft_4point.sv
// Four-point radix-2 IFFT: capture, two butterfly stages, hold result with done.
// Optional IFFT_SCALE_EN gives 1/4 overall scaling inside the butterflies.
module ifft_4point
  import ifft_pkg::*;
#(
  parameter int WIDTH = 2 * COMP_W
) (
  input logic          clk,
  input logic          rst,
  ifft_4point_if.slave bus
);

  localparam tw_sel_e STAGE2_TW = tw_decode(TW_POS_J);

  ifft_state_e             state;
  logic                    done_q;
  logic signed [WIDTH-1:0] x_q   [0:3];
  logic signed [WIDTH-1:0] out_q [0:3];
  logic        [WIDTH-1:0] a0_q;
  logic        [WIDTH-1:0] a1_q;
  logic        [WIDTH-1:0] b0_q;
  logic        [WIDTH-1:0] b1_q;

  logic    [WIDTH-1:0] bf0_a;
  logic    [WIDTH-1:0] bf0_b;
  logic    [WIDTH-1:0] bf1_a;
  logic    [WIDTH-1:0] bf1_b;
  tw_sel_e             bf1_tw;
  logic    [WIDTH-1:0] bf0_sum;
  logic    [WIDTH-1:0] bf0_diff;
  logic    [WIDTH-1:0] bf1_sum;
  logic    [WIDTH-1:0] bf1_diff;

  // The same two butterflies serve both stages; only their operands change.
  always_comb begin
    bf0_a  = x_q[0];
    bf0_b  = x_q[2];
    bf1_a  = x_q[1];
    bf1_b  = x_q[3];
    bf1_tw = TW_SEL_ONE;
    if (state == STAGE2) begin
      bf0_a  = a0_q;
      bf0_b  = b0_q;
      bf1_a  = a1_q;
      bf1_b  = b1_q;
      bf1_tw = STAGE2_TW;
    end
  end

  ifft_butterfly #(.WIDTH(WIDTH)) u_bf0 (
    .a      (bf0_a),
    .b      (bf0_b),
    .tw_sel (TW_SEL_ONE),
    .sum    (bf0_sum),
    .diff   (bf0_diff)
  );

  ifft_butterfly #(.WIDTH(WIDTH)) u_bf1 (
    .a      (bf1_a),
    .b      (bf1_b),
    .tw_sel (bf1_tw),
    .sum    (bf1_sum),
    .diff   (bf1_diff)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
      a0_q   <= '0;
      a1_q   <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= '0;
        out_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q   <= bus.input0;
            state <= STAGE1;
          end
        end
        STAGE1: begin
          a0_q  <= bf0_sum;
          a1_q  <= bf0_diff;
          b0_q  <= bf1_sum;
          b1_q  <= bf1_diff;
          state <= STAGE2;
        end
        STAGE2: begin
          // x0 = a0+b0, x1 = a1+j*b1, x2 = a0-b0, x3 = a1-j*b1
          out_q[0] <= bf0_sum;
          out_q[1] <= bf1_sum;
          out_q[2] <= bf0_diff;
          out_q[3] <= bf1_diff;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (bus.start) begin
            done_q <= 1'b0;
            x_q    <= bus.input0;
            state  <= STAGE1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.output0 = out_q;
  assign bus.done    = done_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_ifft_4point.sv
// Directed bench for ifft_4point; expected results follow IFFT_SCALE_EN.
module tb_ifft_4point;
  import ifft_pkg::*;

  logic clk;
  logic rst;
  int   chk_cnt = 0;
  int   err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out0;

  ifft_4point_if #(.WIDTH(32)) bus ();

  ifft_4point #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Launch one transform from IDLE or DONE, following it edge by edge.
  task automatic transform(input string tag,
                           input logic [31:0] x0, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [31:0] x3,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input bit hold_start, input bit disturb);
    bus.input0[0] = x0;
    bus.input0[1] = x1;
    bus.input0[2] = x2;
    bus.input0[3] = x3;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    check({tag, ".e1_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, ".e1_state"}, 32'(bus.state), 32'(STAGE1));
    check({tag, ".old_out0"}, bus.output0[0], last_out0);
    if (!hold_start) bus.start = 1'b0;
    if (disturb) begin
      for (int i = 0; i < 4; i++) bus.input0[i] = $urandom;
      bus.start = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".e2_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, ".e2_state"}, 32'(bus.state), 32'(STAGE2));
    if (!hold_start) bus.start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".e3_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, ".e3_state"}, 32'(bus.state), 32'(DONE));
    bus.start = 1'b0;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.out%0d", tag, i), bus.output0[i], exp_q.pop_front());
    last_out0 = e0;
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) bus.input0[i] = '0;
    last_out0 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check("rst.state", 32'(bus.state), 32'(IDLE));
    for (int i = 0; i < 4; i++)
      check($sformatf("rst.out%0d", i), bus.output0[i], 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle.state", 32'(bus.state), 32'(IDLE));

`ifdef IFFT_SCALE_EN
    transform("impulse_x0", 32'h0004_0000, 0, 0, 0,
              32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 0);
    transform("impulse_x1_b2b", 0, 32'h0004_0000, 0, 0,
              32'h0001_0000, 32'h0000_0001, 32'hFFFF_0000, 32'h0000_FFFF, 1, 0);
    transform("dc_disturb", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0001_0000, 0, 0, 0, 0, 1);
`else
    transform("impulse_x0", 32'h0004_0000, 0, 0, 0,
              32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    transform("impulse_x1_b2b", 0, 32'h0004_0000, 0, 0,
              32'h0004_0000, 32'h0000_0004, 32'hFFFC_0000, 32'h0000_FFFC, 1, 0);
    transform("dc_disturb", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0004_0000, 0, 0, 0, 0, 1);
`endif

    repeat (3) begin
      @(posedge clk); #1;
      check("hold.done", {31'd0, bus.done}, 32'd1);
      check("hold.out0", bus.output0[0], last_out0);
    end

`ifdef IFFT_SCALE_EN
    transform("full_scale", 32'h7FFF_0000, 0, 32'h7FFF_0000, 0,
              32'h3FFF_0000, 0, 32'h3FFF_0000, 0, 0, 0);
    transform("mixed", 32'h0001_0002, 32'h0003_FFFF, 32'h0000_0005, 32'hFFFE_0000,
              32'h0000_0001, 32'h0000_0000, 32'h0000_0002, 32'hFFFF_FFFE, 0, 0);
    transform("most_neg", 0, 32'h0000_8000, 0, 0,
              32'h0000_E000, 32'h2000_0000, 32'h0000_2000, 32'hE000_0000, 0, 0);
`else
    transform("full_scale", 32'h7FFF_0000, 0, 32'h7FFF_0000, 0,
              32'hFFFE_0000, 0, 32'hFFFE_0000, 0, 0, 0);
    transform("mixed", 32'h0001_0002, 32'h0003_FFFF, 32'h0000_0005, 32'hFFFE_0000,
              32'h0002_0006, 32'h0002_0002, 32'h0000_0008, 32'h0000_FFF8, 0, 0);
    transform("most_neg", 0, 32'h0000_8000, 0, 0,
              32'h0000_8000, 32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 0, 0);
`endif

    // Reset between edges while the next transform sits in STAGE2.
    bus.input0[0] = 32'h0001_0002;
    bus.input0[1] = 32'h0003_FFFF;
    bus.input0[2] = 32'h0000_0005;
    bus.input0[3] = 32'hFFFE_0000;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("mid.state", 32'(bus.state), 32'(STAGE2));
    #2 rst = 1'b0;
    #1;
    check("mid_rst.done", {31'd0, bus.done}, 32'd0);
    check("mid_rst.state", 32'(bus.state), 32'(IDLE));
    for (int i = 0; i < 4; i++)
      check($sformatf("mid_rst.out%0d", i), bus.output0[i], 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst.done", {31'd0, bus.done}, 32'd0);
      check("post_rst.state", 32'(bus.state), 32'(IDLE));
    end
    last_out0 = '0;

`ifdef IFFT_SCALE_EN
    transform("recover", 32'h0004_0000, 0, 0, 0,
              32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 0);
`else
    transform("recover", 32'h0004_0000, 0, 0, 0,
              32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
